// File: rtl/cvxif_copro_if.sv
// CoreV-X-Interface bundle between the core's cvxif unit (master) and the coprocessor (slave).
// Signal names keep the coprocessor-side port names and direction suffixes.
interface cvxif_copro_if #(
    parameter int unsigned XLEN = 64,
    parameter int unsigned ID_W = 3
);
    logic              issue_valid_i;
    logic              issue_ready_o;
    logic [31:0]       issue_instr_i;
    logic [ID_W-1:0]   issue_id_i;
    logic [XLEN-1:0]   issue_rs1_i;
    logic [XLEN-1:0]   issue_rs2_i;
    logic              issue_accept_o;
    logic              issue_writeback_o;
    logic              commit_valid_i;
    logic [ID_W-1:0]   commit_id_i;
    logic              commit_kill_i;
    logic              result_valid_o;
    logic              result_ready_i;
    logic [ID_W-1:0]   result_id_o;
    logic [XLEN-1:0]   result_data_o;
    logic [4:0]        result_rd_o;
    logic              result_we_o;
    logic              result_exc_o;
    logic [5:0]        result_exccode_o;

    modport master (
        output issue_valid_i, issue_instr_i, issue_id_i, issue_rs1_i, issue_rs2_i,
        output commit_valid_i, commit_id_i, commit_kill_i, result_ready_i,
        input  issue_ready_o, issue_accept_o, issue_writeback_o,
        input  result_valid_o, result_id_o, result_data_o, result_rd_o,
        input  result_we_o, result_exc_o, result_exccode_o
    );

    modport slave (
        input  issue_valid_i, issue_instr_i, issue_id_i, issue_rs1_i, issue_rs2_i,
        input  commit_valid_i, commit_id_i, commit_kill_i, result_ready_i,
        output issue_ready_o, issue_accept_o, issue_writeback_o,
        output result_valid_o, result_id_o, result_data_o, result_rd_o,
        output result_we_o, result_exc_o, result_exccode_o
    );
endinterface

// File: rtl/cvxif_copro_responder.sv
// CV-X-IF coprocessor: decodes custom-0 ops, buffers them in order, executes and returns results.
// Optional CROTL instruction enabled by defining CVXIF_COPRO_ROTL_EN.
module cvxif_copro_responder #(
    parameter int unsigned XLEN  = 64,
    parameter int unsigned ID_W  = 3,
    parameter int unsigned DEPTH = 4
) (
    input  logic         clk_i,
    input  logic         rst_i,
    cvxif_copro_if.slave cvxif
);
    localparam int unsigned IDX_W = $clog2(DEPTH);
    localparam int unsigned PTR_W = IDX_W + 1;
`ifdef CVXIF_COPRO_ROTL_EN
    localparam int unsigned SH_W  = $clog2(XLEN);
`endif
    localparam logic [6:0] OPC_CUSTOM0 = 7'b0001011;
    localparam logic [2:0] F3_CADD     = 3'b000;
    localparam logic [2:0] F3_CROTL    = 3'b001;
    localparam logic [2:0] F3_CDELAY   = 3'b011;
    localparam logic [2:0] F3_CEXC     = 3'b100;
    localparam logic [5:0] EXCCODE_CEXC = 6'd2;

    typedef struct packed {
        logic [ID_W-1:0] id;
        logic [2:0]      funct3;
        logic [4:0]      rd;
        logic [XLEN-1:0] rs1;
        logic [XLEN-1:0] rs2;
        logic            committed;
        logic            killed;
    } entry_t;

    typedef enum logic [1:0] {ST_IDLE, ST_EXEC, ST_WAIT, ST_RESP} state_e;

    logic [2:0]      dec_f3_c;
    logic            accept_c;
    logic            writeback_c;
    logic            full_c;
    logic            empty_c;
    logic            push_c;
    logic            pop_c;
    logic            load_ex_c;
    logic            latch_res_c;
    entry_t          new_entry_c;
    entry_t          head_c;
    logic [IDX_W-1:0] wr_idx_c;
    logic [IDX_W-1:0] rd_idx_c;

    entry_t           buf_q [DEPTH];
    logic [DEPTH-1:0] vld_q;
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;

    state_e           state_q, state_d;
    logic [3:0]       cnt_q, cnt_d;
    logic [ID_W-1:0]  ex_id_q;
    logic [2:0]       ex_f3_q;
    logic [4:0]       ex_rd_q;
    logic [XLEN-1:0]  ex_rs1_q;
    logic [XLEN-1:0]  ex_rs2_q;

    logic [XLEN-1:0]  res_data_c;
    logic             res_we_c;
    logic             res_exc_c;
    logic             res_valid_q;
    logic [ID_W-1:0]  res_id_q;
    logic [XLEN-1:0]  res_data_q;
    logic [4:0]       res_rd_q;
    logic             res_we_q;
    logic             res_exc_q;
    logic [5:0]       res_exccode_q;

    // Issue decode; accept is forced low when no request is offered
    assign dec_f3_c = cvxif.issue_instr_i[14:12];

    always_comb begin
        accept_c = 1'b0;
        if (cvxif.issue_valid_i && (cvxif.issue_instr_i[6:0] == OPC_CUSTOM0)) begin
            case (dec_f3_c)
                F3_CADD, F3_CDELAY, F3_CEXC: accept_c = 1'b1;
`ifdef CVXIF_COPRO_ROTL_EN
                F3_CROTL:                    accept_c = 1'b1;
`endif
                default:                     accept_c = 1'b0;
            endcase
        end
    end

    assign writeback_c = accept_c && (dec_f3_c != F3_CEXC);

    assign wr_idx_c = wr_ptr_q[IDX_W-1:0];
    assign rd_idx_c = rd_ptr_q[IDX_W-1:0];
    assign empty_c  = (wr_ptr_q == rd_ptr_q);
    assign full_c   = (wr_ptr_q[IDX_W] != rd_ptr_q[IDX_W]) && (wr_idx_c == rd_idx_c);
    assign push_c   = cvxif.issue_valid_i && !full_c && accept_c;
    assign head_c   = buf_q[rd_idx_c];

    // A commit/kill for the id being pushed this cycle lands on the new entry
    always_comb begin
        new_entry_c.id        = cvxif.issue_id_i;
        new_entry_c.funct3    = dec_f3_c;
        new_entry_c.rd        = cvxif.issue_instr_i[11:7];
        new_entry_c.rs1       = cvxif.issue_rs1_i;
        new_entry_c.rs2       = cvxif.issue_rs2_i;
        new_entry_c.committed = cvxif.commit_valid_i && !cvxif.commit_kill_i &&
                                (cvxif.commit_id_i == cvxif.issue_id_i);
        new_entry_c.killed    = cvxif.commit_valid_i && cvxif.commit_kill_i &&
                                (cvxif.commit_id_i == cvxif.issue_id_i);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            vld_q    <= '0;
        end else begin
            if (pop_c) begin
                vld_q[rd_idx_c] <= 1'b0;
                rd_ptr_q        <= rd_ptr_q + PTR_W'(1);
            end
            if (push_c) begin
                vld_q[wr_idx_c] <= 1'b1;
                wr_ptr_q        <= wr_ptr_q + PTR_W'(1);
            end
        end
    end

    // Entry payload needs no reset; validity is tracked by vld_q
    always_ff @(posedge clk_i) begin
        for (int unsigned i = 0; i < DEPTH; i++) begin
            if (cvxif.commit_valid_i && vld_q[i] && (buf_q[i].id == cvxif.commit_id_i)) begin
                if (cvxif.commit_kill_i) buf_q[i].killed    <= 1'b1;
                else                     buf_q[i].committed <= 1'b1;
            end
        end
        if (push_c) buf_q[wr_idx_c] <= new_entry_c;
    end

    // Head FSM
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        load_ex_c   = 1'b0;
        latch_res_c = 1'b0;
        pop_c       = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (!empty_c) begin
                    load_ex_c = 1'b1;
                    cnt_d     = (head_c.funct3 == F3_CDELAY) ? head_c.rs2[3:0] : 4'd0;
                    state_d   = ST_EXEC;
                end
            end
            ST_EXEC: begin
                if (cnt_q == 4'd0) begin
                    latch_res_c = 1'b1;
                    state_d     = ST_WAIT;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            ST_WAIT: begin
                if (head_c.killed) begin
                    pop_c   = 1'b1;
                    state_d = ST_IDLE;
                end else if (head_c.committed) begin
                    state_d = ST_RESP;
                end
            end
            ST_RESP: begin
                if (cvxif.result_ready_i) begin
                    pop_c   = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Execution datapath
`ifdef CVXIF_COPRO_ROTL_EN
    logic [2*XLEN-1:0] rot_c;
    assign rot_c = {ex_rs1_q, ex_rs1_q} << ex_rs2_q[SH_W-1:0];
`endif

    always_comb begin
        res_data_c = '0;
        res_we_c   = 1'b1;
        res_exc_c  = 1'b0;
        case (ex_f3_q)
            F3_CADD:   res_data_c = ex_rs1_q + ex_rs2_q;
            F3_CDELAY: res_data_c = ex_rs1_q;
            F3_CEXC: begin
                res_we_c  = 1'b0;
                res_exc_c = 1'b1;
            end
`ifdef CVXIF_COPRO_ROTL_EN
            F3_CROTL:  res_data_c = rot_c[2*XLEN-1:XLEN];
`endif
            default:   res_data_c = '0;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q       <= ST_IDLE;
            cnt_q         <= '0;
            ex_id_q       <= '0;
            ex_f3_q       <= '0;
            ex_rd_q       <= '0;
            ex_rs1_q      <= '0;
            ex_rs2_q      <= '0;
            res_valid_q   <= 1'b0;
            res_id_q      <= '0;
            res_data_q    <= '0;
            res_rd_q      <= '0;
            res_we_q      <= 1'b0;
            res_exc_q     <= 1'b0;
            res_exccode_q <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            res_valid_q <= (state_d == ST_RESP);
            if (load_ex_c) begin
                ex_id_q  <= head_c.id;
                ex_f3_q  <= head_c.funct3;
                ex_rd_q  <= head_c.rd;
                ex_rs1_q <= head_c.rs1;
                ex_rs2_q <= head_c.rs2;
            end
            if (latch_res_c) begin
                res_id_q      <= ex_id_q;
                res_data_q    <= res_data_c;
                res_rd_q      <= ex_rd_q;
                res_we_q      <= res_we_c;
                res_exc_q     <= res_exc_c;
                res_exccode_q <= res_exc_c ? EXCCODE_CEXC : 6'd0;
            end
        end
    end

    assign cvxif.issue_ready_o     = !full_c;
    assign cvxif.issue_accept_o    = accept_c;
    assign cvxif.issue_writeback_o = writeback_c;
    assign cvxif.result_valid_o    = res_valid_q;
    assign cvxif.result_id_o       = res_id_q;
    assign cvxif.result_data_o     = res_data_q;
    assign cvxif.result_rd_o       = res_rd_q;
    assign cvxif.result_we_o       = res_we_q;
    assign cvxif.result_exc_o      = res_exc_q;
    assign cvxif.result_exccode_o  = res_exccode_q;
endmodule
